// File: rtl/clk_edge_monitor_pkg.sv
// Shared types and constants for the slow-clock edge monitor.
// Holds the FSM state encoding, the 24-bit counter width and the lock threshold.
// Pure declarations; no logic, no latency, no flow control.
package clk_edge_monitor_pkg;

    localparam int CNT_W = 24;

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,  // no rise seen since reset
        ST_MEASURE = 2'd1,  // one rise seen, first period in progress
        ST_RUN     = 2'd2,  // periods are being captured
        ST_STALL   = 2'd3   // no rise within the timeout window
    } mon_state_t;

    localparam int         GOOD_W    = 3;
    localparam logic [2:0] GOOD_LOCK = 3'd4;

    // Magnitude of the difference between two counter values.
    function automatic cnt_t abs_diff(input cnt_t a, input cnt_t b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/clk_edge_monitor_sync_edge_detect.sv
// Synchronizes an asynchronous level and emits one-cycle rise/fall pulses.
// Latency: pulse is visible after the 3rd clk edge that samples the new level.
// Backpressure: none; free-running, one pulse per detected transition.
//
// Ports: clk, rst (async active-high), async_in (level under observation),
//        rise / fall (registered one-cycle pulses).
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise,
    output logic fall
);

    logic sync_1;
    logic sync_2;
    logic hist;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            hist   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_1 <= async_in;
            sync_2 <= sync_1;
            hist   <= sync_2;
            // hist lags sync_2 by one cycle, so each pulse lasts exactly one cycle
            rise   <= sync_2 & ~hist;
            fall   <= ~sync_2 & hist;
        end
    end

endmodule

// File: rtl/clk_edge_monitor.sv
// Monitors a divided clock: edge pulses, rise-to-rise period, stall timeout.
// Latency: pulses 3 cycles after the input level is sampled; period/status 1 cycle after a pulse.
// Backpressure: none; outputs are free-running status registers.
//
// Ports: i_clk, i_rst (async active-high), i_slow_clk (async input),
//        o_rise_pulse / o_fall_pulse, o_period[23:0], o_period_valid, o_timeout,
//        o_locked (only when CLK_MON_LOCK_EN is defined: period stable within TOLERANCE).
module clk_edge_monitor
    import clk_edge_monitor_pkg::*;
#(
    parameter cnt_t EXPECTED_PERIOD = 24'd198,
    parameter cnt_t TOLERANCE       = 24'd2,
    parameter cnt_t TIMEOUT_CYCLES  = 24'd1000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_slow_clk,
    output logic             o_rise_pulse,
    output logic             o_fall_pulse,
    output logic [CNT_W-1:0] o_period,
    output logic             o_period_valid,
    output logic             o_timeout
`ifdef CLK_MON_LOCK_EN
    ,
    output logic             o_locked
`endif
);

    mon_state_t state;
    mon_state_t state_nxt;
    cnt_t       cnt;
    logic       capture;
    logic       stall_entry;

    sync_edge_detect u_sync_edge_detect (
        .clk      (i_clk),
        .rst      (i_rst),
        .async_in (i_slow_clk),
        .rise     (o_rise_pulse),
        .fall     (o_fall_pulse)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A rise always takes priority over the timeout compare, so an edge landing
    // exactly on the timeout cycle is captured as a period instead of stalling.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (o_rise_pulse) state_nxt = ST_MEASURE;
            end
            ST_MEASURE: begin
                if (o_rise_pulse) begin
                    state_nxt = ST_RUN;
                    capture   = 1'b1;
                end else if (cnt == TIMEOUT_CYCLES) begin
                    state_nxt = ST_STALL;
                end
            end
            ST_RUN: begin
                if (o_rise_pulse) begin
                    capture   = 1'b1;
                end else if (cnt == TIMEOUT_CYCLES) begin
                    state_nxt = ST_STALL;
                end
            end
            ST_STALL: begin
                if (o_rise_pulse) state_nxt = ST_MEASURE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        stall_entry = (state_nxt == ST_STALL) && (state != ST_STALL);
    end

    // Counter restarts at 1 on the rise cycle, so its value when the next rise is
    // seen equals the rise-to-rise spacing. Saturates rather than wrapping.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (o_rise_pulse) begin
            cnt <= cnt_t'(1);
        end else if (cnt != CNT_MAX) begin
            cnt <= cnt + cnt_t'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_period       <= '0;
            o_period_valid <= 1'b0;
            o_timeout      <= 1'b0;
        end else begin
            if (capture) o_period <= cnt;
            o_period_valid <= (state_nxt == ST_RUN);
            o_timeout      <= (state_nxt == ST_STALL);
        end
    end

`ifdef CLK_MON_LOCK_EN
    logic [GOOD_W-1:0] good_cnt;
    logic [GOOD_W-1:0] good_nxt;
    logic              period_ok;

    always_comb begin
        period_ok = (abs_diff(cnt, EXPECTED_PERIOD) <= TOLERANCE);
        good_nxt  = good_cnt;
        if (stall_entry || (capture && !period_ok)) begin
            good_nxt = '0;
        end else if (capture && (good_cnt != GOOD_LOCK)) begin
            good_nxt = good_cnt + 3'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            good_cnt <= '0;
            o_locked <= 1'b0;
        end else begin
            good_cnt <= good_nxt;
            o_locked <= (good_nxt == GOOD_LOCK);
        end
    end
`else
    // Lock qualification is compiled out; these only keep the parameters referenced.
    logic unused_lock_cfg;
    assign unused_lock_cfg = ^{EXPECTED_PERIOD, TOLERANCE, stall_entry};
`endif

endmodule

// File: tb/tb_clk_edge_monitor.sv
// Self-checking bench for clk_edge_monitor: time-based reference model compared
// every cycle, plus hand-computed literal checks at scenario milestones.
// Stimulus changes i_slow_clk only on falling edges of i_clk.
module tb_clk_edge_monitor;

    localparam int EXP_P = 198;
    localparam int TOL   = 2;
    localparam int TMO   = 1000;

    logic        i_clk;
    logic        i_rst;
    logic        i_slow_clk;
    logic        o_rise_pulse;
    logic        o_fall_pulse;
    logic [23:0] o_period;
    logic        o_period_valid;
    logic        o_timeout;
`ifdef CLK_MON_LOCK_EN
    logic        o_locked;
`endif

    int total = 0;
    int bad   = 0;

    clk_edge_monitor #(
        .EXPECTED_PERIOD (24'd198),
        .TOLERANCE       (24'd2),
        .TIMEOUT_CYCLES  (24'd1000)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_slow_clk     (i_slow_clk),
        .o_rise_pulse   (o_rise_pulse),
        .o_fall_pulse   (o_fall_pulse),
        .o_period       (o_period),
        .o_period_valid (o_period_valid),
        .o_timeout      (o_timeout)
`ifdef CLK_MON_LOCK_EN
        ,
        .o_locked       (o_locked)
`endif
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pulses: a transition is reported once the new level has been sampled on
    // three consecutive edges (samp holds the last four edge samples).
    // Timing: a rise pulse is acted on at the following edge; the period is the
    // edge-count distance between two such edges; a stall is declared when
    // TMO edges pass after a rise with no new rise (not before the first rise).
    bit          samp [4];
    bit          m_rise;
    bit          m_fall;
    bit          m_have_ref;   // at least one rise since reset / stall
    bit          m_valid;
    bit          m_stalled;
    int          m_edge;
    int          m_ref_edge;
    logic [23:0] m_period;
    int          m_good;
    bit          m_locked;

    initial begin
        m_rise = 0; m_fall = 0; m_have_ref = 0; m_valid = 0; m_stalled = 0;
        m_edge = 0; m_ref_edge = 0; m_period = '0; m_good = 0; m_locked = 0;
        for (int i = 0; i < 4; i++) samp[i] = 0;
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) begin
                for (int i = 0; i < 4; i++) samp[i] = 0;
                m_rise = 0; m_fall = 0; m_have_ref = 0; m_valid = 0;
                m_stalled = 0; m_period = '0; m_good = 0; m_locked = 0;
            end else begin
                m_edge++;
                if (m_rise) begin
                    if (m_have_ref && !m_stalled) begin
                        int p;
                        int d;
                        p = m_edge - m_ref_edge;
                        m_period = p[23:0];
                        m_valid = 1;
                        d = (p > EXP_P) ? p - EXP_P : EXP_P - p;
                        if (d <= TOL) m_good = (m_good < 4) ? m_good + 1 : 4;
                        else          m_good = 0;
                    end
                    m_have_ref = 1;
                    m_stalled  = 0;
                    m_ref_edge = m_edge;
                end else if (m_have_ref && !m_stalled && (m_edge - m_ref_edge == TMO)) begin
                    m_stalled = 1;
                    m_valid   = 0;
                    m_good    = 0;
                end
                m_locked = (m_good == 4);
                samp[3] = samp[2];
                samp[2] = samp[1];
                samp[1] = samp[0];
                samp[0] = i_slow_clk;
                m_rise = samp[2] && !samp[3];
                m_fall = !samp[2] && samp[3];
            end
        end
    end

    // Per-cycle comparison, sampled on the falling edge.
    always @(negedge i_clk) begin
        chk("rise_pulse", {31'd0, o_rise_pulse}, {31'd0, m_rise});
        chk("fall_pulse", {31'd0, o_fall_pulse}, {31'd0, m_fall});
        chk("period", {8'd0, o_period}, {8'd0, m_period});
        chk("period_valid", {31'd0, o_period_valid}, {31'd0, m_valid});
        chk("timeout", {31'd0, o_timeout}, {31'd0, m_stalled});
`ifdef CLK_MON_LOCK_EN
        chk("locked", {31'd0, o_locked}, {31'd0, m_locked});
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic lvl, input int n);
        i_slow_clk = lvl;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rise"},   {31'd0, o_rise_pulse}, 32'd0);
        chk({tag, "_fall"},   {31'd0, o_fall_pulse}, 32'd0);
        chk({tag, "_period"}, {8'd0, o_period}, 32'd0);
        chk({tag, "_valid"},  {31'd0, o_period_valid}, 32'd0);
        chk({tag, "_tmo"},    {31'd0, o_timeout}, 32'd0);
`ifdef CLK_MON_LOCK_EN
        chk({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
`endif
    endtask

    initial begin
        i_rst      = 1'b1;
        i_slow_clk = 1'b0;
        repeat (3) @(negedge i_clk);
        chk_all_zero("reset");
        i_rst = 1'b0;
        drive(0, 10);

        // Rise latency: pulse on the 3rd edge after the input goes high.
        i_slow_clk = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge i_clk);
            chk($sformatf("rise_lat_k%0d", k), {31'd0, o_rise_pulse}, (k == 3) ? 32'd1 : 32'd0);
        end
        drive(1, 96);
        chk("first_rise_valid", {31'd0, o_period_valid}, 32'd0);

        // Fall latency: identical to the rise.
        i_slow_clk = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge i_clk);
            chk($sformatf("fall_lat_k%0d", k), {31'd0, o_fall_pulse}, (k == 3) ? 32'd1 : 32'd0);
        end
        drive(0, 96);

        // Second rise: first period captured.
        drive(1, 99);
        chk("p198_period", {8'd0, o_period}, 32'd198);
        chk("p198_valid", {31'd0, o_period_valid}, 32'd1);
        drive(0, 99);
        drive(1, 99);
        chk("p198b_period", {8'd0, o_period}, 32'd198);

        // Hold low: stall after 1000 cycles.
        drive(0, 1100);
        chk("stall_tmo", {31'd0, o_timeout}, 32'd1);
        chk("stall_valid", {31'd0, o_period_valid}, 32'd0);
        chk("stall_period_hold", {8'd0, o_period}, 32'd198);
        drive(1, 99);
        chk("unstall_tmo", {31'd0, o_timeout}, 32'd0);
        chk("unstall_valid", {31'd0, o_period_valid}, 32'd0);
        drive(0, 99);
        drive(1, 99);
        chk("revalid_valid", {31'd0, o_period_valid}, 32'd1);
        chk("revalid_period", {8'd0, o_period}, 32'd198);

        // Rise spaced exactly the timeout: the rise wins.
        drive(0, 901);
        drive(1, 99);
        chk("edge_tmo_period", {8'd0, o_period}, 32'd1000);
        chk("edge_tmo_valid", {31'd0, o_period_valid}, 32'd1);
        chk("edge_tmo_tmo", {31'd0, o_timeout}, 32'd0);

        // Four periods of 199, then one of 210.
        repeat (4) begin
            drive(0, 100);
            drive(1, 99);
        end
        chk("p199_period", {8'd0, o_period}, 32'd199);
`ifdef CLK_MON_LOCK_EN
        chk("p199_locked", {31'd0, o_locked}, 32'd1);
`endif
        drive(0, 111);
        drive(1, 99);
        chk("p210_period", {8'd0, o_period}, 32'd210);
`ifdef CLK_MON_LOCK_EN
        chk("p210_locked", {31'd0, o_locked}, 32'd0);
`endif

        // Reset mid-period: outputs clear immediately.
        drive(0, 50);
        @(posedge i_clk);
        #2;
        i_rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;

        // Constant level after reset never times out.
        drive(0, 1100);
        chk("idle_tmo", {31'd0, o_timeout}, 32'd0);
        chk("idle_valid", {31'd0, o_period_valid}, 32'd0);
        drive(1, 99);
        chk("post_rst_r1_valid", {31'd0, o_period_valid}, 32'd0);
        chk("post_rst_r1_period", {8'd0, o_period}, 32'd0);
        drive(0, 99);
        drive(1, 99);
        chk("post_rst_r2_valid", {31'd0, o_period_valid}, 32'd1);
        chk("post_rst_r2_period", {8'd0, o_period}, 32'd198);
        drive(0, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_edge_monitor.md
CLK_EDGE_MONITOR -- requirements
Module: clk_edge_monitor

Interface
REQ-001 SHALL have parameter EXPECTED_PERIOD, default 24'd198, giving the nominal slow-clock period in i_clk cycles (twice the divider ratio).
REQ-002 SHALL have parameter TOLERANCE, default 24'd2, giving the allowed |period - EXPECTED_PERIOD| in cycles.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 24'd1000, giving the number of cycles without a rising edge before a stall is declared.
REQ-004 i_clk  input  1  system clock, the sole clock.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_slow_clk  input  1  divided clock under observation, treated as asynchronous.
REQ-007 o_rise_pulse  output  1  one-cycle pulse per detected rising edge.
REQ-008 o_fall_pulse  output  1  one-cycle pulse per detected falling edge.
REQ-009 o_period  output  24  last measured rise-to-rise period in i_clk cycles.
REQ-010 o_period_valid  output  1  o_period holds a real measurement.
REQ-011 o_timeout  output  1  no rising edge seen for TIMEOUT_CYCLES cycles.
REQ-012 o_locked  output  1  present only with CLK_MON_LOCK_EN; the period is stable within tolerance.

Function
REQ-013 SHALL pass i_slow_clk through a two-flop synchronizer, then a history register; all outputs registered.
REQ-014 SHALL assert o_rise_pulse for exactly one cycle, after the third i_clk edge at which i_slow_clk is sampled high following a low sample; o_fall_pulse likewise for falling edges.
REQ-015 SHALL run a 24-bit cycle counter that increments each cycle and saturates at 24'hFFFFFF with no wrap.
REQ-016 On each detected rise, the counter SHALL load 1; in state RUN, o_period SHALL load the counter's pre-update value, so edges spaced P cycles give o_period = P.
REQ-017 FSM states: IDLE (no rise yet), MEASURE (one rise seen), RUN (periods valid), STALL (timed out).
REQ-018 Transitions: IDLE->MEASURE on rise; MEASURE->RUN on rise (first period captured); RUN->RUN on rise; MEASURE/RUN->STALL when counter == TIMEOUT_CYCLES; STALL->MEASURE on rise.
REQ-019 o_period_valid SHALL be high only in RUN; o_period SHALL hold its last value outside RUN.
REQ-020 o_timeout SHALL be high only in STALL.
REQ-021 If a rise and the timeout condition occur in the same cycle, the rise SHALL win and the state SHALL NOT enter STALL.
REQ-022 IDLE SHALL NOT time out; a constant-level input after reset leaves o_timeout = 0.

Reset
REQ-023 On i_rst, asynchronously: state = IDLE, counter = 0, synchronizer and history registers = 0, all outputs = 0 (o_period = 24'd0).
REQ-024 Reset asserted mid-measurement SHALL discard any partial count; the first rise after release SHALL only move the FSM to MEASURE.

Configuration
REQ-025 Macro CLK_MON_LOCK_EN, when defined, SHALL add o_locked and a 3-bit consecutive-good counter.
- A period within TOLERANCE increments the counter, saturating at 4.
- o_locked = 1 when the counter reaches 4.
- An out-of-range period, STALL entry, or reset clears the counter and o_locked.
REQ-026 Without CLK_MON_LOCK_EN, the o_locked port and the lock logic SHALL be absent; all other behaviour is identical.

Structure
REQ-027 The shared package SHALL hold the FSM state encoding (2 bits: IDLE, MEASURE, RUN, STALL) and the 24-bit counter width constant.
REQ-028 The synchronizer-plus-edge-detector SHALL be a sub-module named sync_edge_detect, outputting the rise/fall pulses.

Verification
REQ-029 Slow clock with period 198 (99 high / 99 low): o_period = 198 and o_period_valid = 1 from the second rise onward; o_rise_pulse width = 1 cycle.
REQ-030 Input rises at a known edge: o_rise_pulse asserts 3 i_clk edges later; the falling-edge latency is identical.
REQ-031 Hold the input low after 3 rises: o_timeout = 1 and o_period_valid = 0 after 1000 cycles; the next rise clears o_timeout, and the following rise restores valid.
REQ-032 Force a rise on exactly the timeout cycle: the FSM stays in RUN, o_timeout stays 0, and o_period = 1000.
REQ-033 With CLK_MON_LOCK_EN: four periods of 199 give o_locked = 1; a single period of 210 drops o_locked to 0 on that capture.
REQ-034 Assert i_rst mid-period: all outputs are 0 immediately; after release, o_period_valid is first set at the second rise.
